// File: rtl/freq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : freq_pkg
// Description : Shared constants, converter state type and BCD adjust helper
//               for the gated frequency counter.
// Revision    : 1.0 - initial release
// ============================================================================
package freq_pkg;

   localparam int         COUNT_W    = 14;
   localparam int         MAX_COUNT  = 9999;
   localparam int         SAT_COUNT  = 10000;
   localparam logic [3:0] DIGIT_DASH = 4'hF;
   localparam int         BCD_ITER   = 14;
   localparam int         BCD_W      = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      LOAD = 2'd2
   } conv_state_t;

   // Add 3 to every nibble that is 5 or more, ahead of a double-dabble shift.
   function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] bcd);
      logic [BCD_W-1:0] res;
      res = bcd;
      for (int i = 0; i < BCD_W / 4; i++) begin
         if (bcd[i*4 +: 4] >= 4'd5) begin
            res[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
         end
      end
      return res;
   endfunction

endpackage
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : bin2bcd_seq
// Description : Sequential double-dabble binary-to-BCD converter, one bit
//               per clock. start in IDLE loads bin; done marks the LOAD cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_seq
   import freq_pkg::*;
(
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   input  logic [COUNT_W-1:0] bin,
   output logic               busy,
   output logic               done,
   output logic [BCD_W-1:0]   bcd
);

   localparam logic [3:0] c_LAST_ITER = 4'(BCD_ITER - 1);

   conv_state_t                r_state;
   conv_state_t                w_state_next;
   logic [3:0]                 r_iter;
   logic [BCD_W+COUNT_W-1:0]   r_shift;

   // State register; reset aborts any conversion in flight.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next state: IDLE -> CONV on start, CONV for BCD_ITER cycles, one LOAD cycle.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (start) w_state_next = CONV;
         CONV:    if (r_iter == c_LAST_ITER) w_state_next = LOAD;
         LOAD:    w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   // Shift register and iteration counter; result holds outside CONV.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_iter  <= 4'd0;
         r_shift <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_shift <= {{BCD_W{1'b0}}, bin};
                  r_iter  <= 4'd0;
               end
            end
            CONV: begin
               r_shift <= {bcd_adjust(r_shift[BCD_W+COUNT_W-1:COUNT_W]),
                           r_shift[COUNT_W-1:0]} << 1;
               r_iter  <= r_iter + 4'd1;
            end
            default: begin
            end
         endcase
      end
   end

   assign busy = (r_state != IDLE);
   assign done = (r_state == LOAD);
   assign bcd  = r_shift[BCD_W+COUNT_W-1:COUNT_W];

endmodule
`default_nettype wire

// File: rtl/freq_gate_bcd.sv
`default_nettype none
// ============================================================================
// Module      : freq_gate_bcd
// Description : Counts rising edges of sig_in over a fixed gate window and
//               presents the count as four BCD digits (dashes on overflow).
// Revision    : 1.0 - initial release
// ============================================================================
module freq_gate_bcd
   import freq_pkg::*;
#(
   parameter int CLK_HZ  = 100_000_000,
   parameter int GATE_MS = 1000
)
(
   input  logic       clock,
   input  logic       reset,
   input  logic       sig_in,
   output logic [3:0] digit0,
   output logic [3:0] digit1,
   output logic [3:0] digit2,
   output logic [3:0] digit3,
   output logic       overflow,
   output logic       valid
);

   localparam longint GATE_CYCLES = (64'(CLK_HZ) * 64'(GATE_MS)) / 64'd1000;
   localparam int     GATE_W      = $clog2(GATE_CYCLES);

   // A gate shorter than one full conversion would restart a busy converter.
   if (GATE_CYCLES < 64'd16) begin : g_gate_too_short
      $error("freq_gate_bcd: GATE_CYCLES must be at least 16");
   end

   logic               r_sync1;
   logic               r_sync2;
   logic               r_sync_prev;
   logic               w_edge;
   logic [GATE_W-1:0]  r_gate_cnt;
   logic               w_terminal;
   logic [COUNT_W-1:0] r_edge_cnt;
   logic [COUNT_W-1:0] w_edge_next;
   logic [COUNT_W-1:0] r_snapshot;
   logic               w_busy;
   logic               w_done;
   logic [BCD_W-1:0]   w_bcd;

   // Two-flop synchronizer followed by the edge-detect history flop.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_sync1     <= 1'b0;
         r_sync2     <= 1'b0;
         r_sync_prev <= 1'b0;
      end else begin
         r_sync1     <= sig_in;
         r_sync2     <= r_sync1;
         r_sync_prev <= r_sync2;
      end
   end

   assign w_edge     = r_sync2 & ~r_sync_prev;
   assign w_terminal = (r_gate_cnt == GATE_W'(GATE_CYCLES - 64'd1));

   // Saturating count including this cycle's edge, so a terminal-cycle edge
   // lands in the window that is closing.
   assign w_edge_next = (r_edge_cnt == COUNT_W'(SAT_COUNT)) ? r_edge_cnt
                        : r_edge_cnt + {{(COUNT_W-1){1'b0}}, w_edge};

   // Free-running gate counter, edge counter and end-of-gate snapshot.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_gate_cnt <= '0;
         r_edge_cnt <= '0;
         r_snapshot <= '0;
      end else if (w_terminal) begin
         r_gate_cnt <= '0;
         r_edge_cnt <= '0;
         r_snapshot <= w_edge_next;
      end else begin
         r_gate_cnt <= r_gate_cnt + GATE_W'(1);
         r_edge_cnt <= w_edge_next;
      end
   end

   bin2bcd_seq u_bin2bcd (
      .clock (clock),
      .reset (reset),
      .start (w_terminal),
      .bin   (w_edge_next),
      .busy  (w_busy),
      .done  (w_done),
      .bcd   (w_bcd)
   );

   // Display registers update only in the converter's LOAD cycle.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         digit0   <= 4'd0;
         digit1   <= 4'd0;
         digit2   <= 4'd0;
         digit3   <= 4'd0;
         overflow <= 1'b0;
         valid    <= 1'b0;
      end else begin
         valid <= w_done;
         if (w_done) begin
            if (r_snapshot >= COUNT_W'(SAT_COUNT)) begin
               digit0   <= DIGIT_DASH;
               digit1   <= DIGIT_DASH;
               digit2   <= DIGIT_DASH;
               digit3   <= DIGIT_DASH;
               overflow <= 1'b1;
            end else begin
               digit0   <= w_bcd[3:0];
               digit1   <= w_bcd[7:4];
               digit2   <= w_bcd[11:8];
               digit3   <= w_bcd[15:12];
               overflow <= 1'b0;
            end
         end
      end
   end

   a_gate_in_idle: assert property (@(posedge clock) disable iff (reset)
                                    w_terminal |-> !w_busy);

endmodule
`default_nettype wire

// File: tb/tb_freq_gate_bcd.sv
`default_nettype none
// ============================================================================
// Module      : tb_freq_gate_bcd
// Description : Scoreboard bench for freq_gate_bcd. Instance A has a 100-cycle
//               gate with random patterns and a mid-conversion reset; instance
//               B has a 21000-cycle gate for the 9999/10000/1234 boundaries.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_freq_gate_bcd;

   localparam int GA = 100;     // 1000 Hz, 100 ms
   localparam int GB = 21000;   // 21000 Hz, 1000 ms

   typedef struct {
      int          cyc;
      logic [15:0] dig;
      logic        ov;
   } exp_t;

   logic       clock = 1'b0;
   logic       rst_a, rst_b, sig_a, sig_b;
   logic [3:0] da0, da1, da2, da3, db0, db1, db2, db3;
   logic       ova, va, ovb, vb;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc_a = 0, cyc_b = 0;
   bit   run_a = 0, run_b = 0, stop_all = 0;
   logic prev_a = 1'b0, prev_b = 1'b0;
   logic [16:0] last_a = '0, last_b = '0;
   int   win_a [0:1023];
   int   win_b [0:7];
   exp_t exp_a [$];
   exp_t exp_b [$];

   always #5 clock = ~clock;

   freq_gate_bcd #(.CLK_HZ(1000), .GATE_MS(100)) dut_a (
      .clock(clock), .reset(rst_a), .sig_in(sig_a),
      .digit0(da0), .digit1(da1), .digit2(da2), .digit3(da3),
      .overflow(ova), .valid(va));

   freq_gate_bcd #(.CLK_HZ(21000), .GATE_MS(1000)) dut_b (
      .clock(clock), .reset(rst_b), .sig_in(sig_b),
      .digit0(db0), .digit1(db1), .digit2(db2), .digit3(db3),
      .overflow(ovb), .valid(vb));

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                  name, act, act, exp, exp, $time);
      end
   endtask

   // Expected display for a gate count, from the decimal value itself.
   function automatic exp_t make_exp(input int c, input int cnt);
      exp_t e;
      int   s;
      s     = (cnt > 10000) ? 10000 : cnt;
      e.cyc = c;
      if (s >= 10000) begin
         e.dig = 16'hFFFF;
         e.ov  = 1'b1;
      end else begin
         e.dig = {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
         e.ov  = 1'b0;
      end
      return e;
   endfunction

   // Drive one cycle of A; a 0->1 step is seen 2 cycles later, in window (c+2)/G.
   task automatic drive_a(input logic v);
      sig_a = v;
      if (v && !prev_a) win_a[(cyc_a + 2) / GA]++;
      prev_a = v;
      if (cyc_a % GA == GA - 1) exp_a.push_back(make_exp(cyc_a + 16, win_a[cyc_a / GA]));
   endtask

   task automatic drive_b(input logic v);
      sig_b = v;
      if (v && !prev_b) win_b[(cyc_b + 2) / GB]++;
      prev_b = v;
      if (cyc_b % GB == GB - 1) exp_b.push_back(make_exp(cyc_b + 16, win_b[cyc_b / GB]));
   endtask

   // A patterns: square/4, low, high, random, sparse, edge late in the gate.
   function automatic logic a_val(input int mode, input int o);
      case (mode)
         0:       return (o % 4) < 2;
         1:       return 1'b0;
         2:       return 1'b1;
         3:       return logic'($urandom % 2);
         4:       return ($urandom % 6) == 0;
         default: return ((o < 90) && ((o % 4) < 2)) || (o == GA - 3);
      endcase
   endfunction

   // B: 9999 edges, 10000 edges, 1234 edges of varying width, then quiet.
   function automatic logic b_val(input int n);
      int w, o;
      w = n / GB;
      o = n % GB;
      case (w)
         0:       return (o >= 100) && (o < 100 + 19998) && ((o - 100) % 2 == 0);
         1:       return (o >= 100) && (o < 100 + 20000) && ((o - 100) % 2 == 0);
         2:       return (o >= 100) && (o < 100 + 1234 * 16) &&
                         (((o - 100) % 16) < 1 + (((o - 100) / 16) % 7));
         default: return 1'b0;
      endcase
   endfunction

   // Monitor A: pop on valid, otherwise outputs must hold.
   initial begin
      exp_t e;
      forever begin
         @(posedge clock);
         #2;
         if (run_a && !rst_a && !stop_all) begin
            if (va) begin
               if (exp_a.size() == 0) check("a_unexpected_valid", 1, 0);
               else begin
                  e = exp_a.pop_front();
                  check("a_valid_cycle", cyc_a, e.cyc);
                  check("a_digits", {da3, da2, da1, da0}, e.dig);
                  check("a_overflow", ova, e.ov);
                  last_a = {e.ov, e.dig};
               end
            end else begin
               check("a_hold", {ova, da3, da2, da1, da0}, last_a);
            end
         end
      end
   end

   // Monitor B.
   initial begin
      exp_t e;
      forever begin
         @(posedge clock);
         #2;
         if (run_b && !rst_b && !stop_all) begin
            if (vb) begin
               if (exp_b.size() == 0) check("b_unexpected_valid", 1, 0);
               else begin
                  e = exp_b.pop_front();
                  check("b_valid_cycle", cyc_b, e.cyc);
                  check("b_digits", {db3, db2, db1, db0}, e.dig);
                  check("b_overflow", ovb, e.ov);
                  last_b = {e.ov, e.dig};
               end
            end else begin
               check("b_hold", {ovb, db3, db2, db1, db0}, last_b);
            end
         end
      end
   end

   // Stimulus A, including an asynchronous reset during a conversion.
   initial begin
      int  mode;
      bit  did_reset;
      int  seq [0:5];
      seq = '{0, 1, 2, 2, 5, 0};
      did_reset = 0;
      mode = 0;
      rst_a = 1'b1;
      sig_a = 1'b0;
      for (int i = 0; i < 1024; i++) win_a[i] = 0;
      repeat (4) @(posedge clock);
      #1;
      rst_a = 1'b0;
      cyc_a = 0;
      run_a = 1;
      while (!stop_all) begin
         if (cyc_a % GA == 0)
            mode = (!did_reset && cyc_a / GA < 6) ? seq[cyc_a / GA] : int'($urandom_range(0, 5));
         drive_a(a_val(mode, cyc_a % GA));
         if (!did_reset && cyc_a == 6 * GA - 1 + 5) begin
            did_reset = 1;
            #3;
            rst_a = 1'b1;
            #1;
            check("a_rst_digits", {da3, da2, da1, da0}, 0);
            check("a_rst_overflow", ova, 0);
            check("a_rst_valid", va, 0);
            exp_a.delete();
            for (int i = 0; i < 1024; i++) win_a[i] = 0;
            last_a = '0;
            prev_a = 1'b0;
            sig_a  = 1'b0;
            repeat (3) @(posedge clock);
            #1;
            rst_a = 1'b0;
            cyc_a = 0;
         end else begin
            @(posedge clock);
            #1;
            cyc_a++;
         end
      end
   end

   // Stimulus B and end of test.
   initial begin
      rst_b = 1'b1;
      sig_b = 1'b0;
      for (int i = 0; i < 8; i++) win_b[i] = 0;
      repeat (3) @(posedge clock);
      #1;
      check("a_init_digits", {da3, da2, da1, da0}, 0);
      check("a_init_flags", {ova, va}, 0);
      check("b_init_digits", {db3, db2, db1, db0}, 0);
      check("b_init_flags", {ovb, vb}, 0);
      @(posedge clock);
      #1;
      rst_b = 1'b0;
      cyc_b = 0;
      run_b = 1;
      while (cyc_b < 3 * GB + 20) begin
         drive_b(b_val(cyc_b));
         @(posedge clock);
         #1;
         cyc_b++;
      end
      stop_all = 1;
      check("b_missing_valid", exp_b.size(), 0);
      if (exp_a.size() > 0) check("a_missing_valid", (exp_a[0].cyc >= cyc_a) ? 1 : 0, 1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
